// File: rtl/buttonpress_pkg.sv
// Shared types and width helpers for the debounced button-press bank.
package buttonpress_pkg;

  typedef enum logic [1:0] {
    WAIT_UP     = 2'd0,
    BTN_UP      = 2'd1,
    DEBOUNCE    = 2'd2,
    BTN_PRESSED = 2'd3
  } state_t;

  // Counter width able to hold 0..max inclusive.
  function automatic int cnt_width(input int max);
    return $clog2(max) + 1;
  endfunction

  function automatic int idx_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One debounced button: press latched until acknowledged, optional long-press flag.
module button_channel
  import buttonpress_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 3,
  parameter int LONG_PRESS_CYCLES = 0
) (
  input  logic clock,
  input  logic reset,
  input  logic buttonDown,
  input  logic ackPress,
  output logic wasPressed,
  output logic wasLongPress
);

  localparam int DW = cnt_width(DEBOUNCE_CYCLES);
  localparam int HW = cnt_width(LONG_PRESS_CYCLES);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES);
  localparam logic LONG_EN = (LONG_PRESS_CYCLES > 0);

  state_t        state_reg;
  logic [DW-1:0] db_count_reg;
  logic [HW-1:0] hold_count_reg;
  logic          frozen_reg;
  logic          long_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= WAIT_UP;
      db_count_reg   <= '0;
      hold_count_reg <= '0;
      frozen_reg     <= 1'b0;
      long_reg       <= 1'b0;
    end else begin
      case (state_reg)
        WAIT_UP: begin
          if (!buttonDown) state_reg <= BTN_UP;
        end
        BTN_UP: begin
          if (buttonDown) begin
            state_reg    <= DEBOUNCE;
            db_count_reg <= DW'(1);
          end
        end
        DEBOUNCE: begin
          if (!buttonDown) begin
            state_reg <= BTN_UP;
          end else if (db_count_reg == DB_LAST) begin
            state_reg      <= BTN_PRESSED;
            hold_count_reg <= '0;
            frozen_reg     <= 1'b0;
          end else begin
            db_count_reg <= db_count_reg + 1'b1;
          end
        end
        BTN_PRESSED: begin
          if (ackPress) begin
            state_reg <= WAIT_UP;
            long_reg  <= 1'b0;
          end else if (!buttonDown) begin
            // Any release ends hold counting for this press, even if re-pressed.
            frozen_reg <= 1'b1;
          end else if (LONG_EN && !frozen_reg && !long_reg && hold_count_reg != HOLD_LAST) begin
            hold_count_reg <= hold_count_reg + 1'b1;
            if (hold_count_reg + 1'b1 == HOLD_LAST) long_reg <= 1'b1;
          end
        end
        default: state_reg <= WAIT_UP;
      endcase
    end
  end

  assign wasPressed   = (state_reg == BTN_PRESSED);
  assign wasLongPress = long_reg;

endmodule

// File: rtl/button_press_bank.sv
// Bank of independent debounced buttons with any-pressed and lowest-pending-index summaries.
module button_press_bank
  import buttonpress_pkg::*;
#(
  parameter int CHANNELS          = 4,
  parameter int DEBOUNCE_CYCLES   = 3,
  parameter int LONG_PRESS_CYCLES = 0
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [CHANNELS-1:0]              buttonDown,
  input  logic [CHANNELS-1:0]              ackPress,
  output logic [CHANNELS-1:0]              wasPressed,
  output logic [CHANNELS-1:0]              wasLongPress,
  output logic                             anyPressed,
  output logic [idx_width(CHANNELS)-1:0]   pressedIndex
);

  localparam int IW = idx_width(CHANNELS);

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      button_channel #(
        .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
        .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
      ) u_ch (
        .clock       (clock),
        .reset       (reset),
        .buttonDown  (buttonDown[gi]),
        .ackPress    (ackPress[gi]),
        .wasPressed  (wasPressed[gi]),
        .wasLongPress(wasLongPress[gi])
      );
    end
  endgenerate

  assign anyPressed = |wasPressed;

  // Scan high to low so the lowest pending channel wins.
  always_comb begin
    pressedIndex = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (wasPressed[i]) pressedIndex = IW'(i);
    end
  end

endmodule

// File: tb/tb_button_press_bank.sv
// Randomised and directed check of button_press_bank (default and long-press builds) against a behavioural model.
module tb_button_press_bank;

  localparam int CH = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [CH-1:0] bd;
  logic [CH-1:0] ack;
  logic [CH-1:0] wp_a, wl_a, wp_b, wl_b;
  logic          any_a, any_b;
  logic [1:0]    idx_a, idx_b;

  int  vectors = 0;
  int  errors  = 0;
  bit  run_cmp = 0;

  // Model: per instance (0 = defaults, 1 = long press 5), per channel.
  bit m_pr    [2][CH];
  bit m_armed [2][CH];
  int m_streak[2][CH];
  int m_hold  [2][CH];
  bit m_frz   [2][CH];
  bit m_long  [2][CH];

  button_press_bank #(.CHANNELS(CH), .DEBOUNCE_CYCLES(3), .LONG_PRESS_CYCLES(0)) dut_a (
    .clock(clock), .reset(reset), .buttonDown(bd), .ackPress(ack),
    .wasPressed(wp_a), .wasLongPress(wl_a), .anyPressed(any_a), .pressedIndex(idx_a));

  button_press_bank #(.CHANNELS(CH), .DEBOUNCE_CYCLES(3), .LONG_PRESS_CYCLES(5)) dut_b (
    .clock(clock), .reset(reset), .buttonDown(bd), .ackPress(ack),
    .wasPressed(wp_b), .wasLongPress(wl_b), .anyPressed(any_b), .pressedIndex(idx_b));

  initial forever #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int long_thr(input int inst);
    return (inst == 1) ? 5 : 0;
  endfunction

  // A press needs a release seen since reset/ack, then DEBOUNCE+1 consecutive down samples.
  always @(posedge clock) begin
    for (int n = 0; n < 2; n++) begin
      for (int c = 0; c < CH; c++) begin
        if (reset) begin
          m_pr[n][c] = 0; m_armed[n][c] = 0; m_streak[n][c] = 0;
          m_hold[n][c] = 0; m_frz[n][c] = 0; m_long[n][c] = 0;
        end else if (m_pr[n][c]) begin
          if (ack[c]) begin
            m_pr[n][c] = 0; m_long[n][c] = 0; m_armed[n][c] = 0; m_streak[n][c] = 0;
          end else if (!bd[c]) begin
            m_frz[n][c] = 1;
          end else if (long_thr(n) > 0 && !m_frz[n][c] && !m_long[n][c]) begin
            m_hold[n][c] = m_hold[n][c] + 1;
            if (m_hold[n][c] == long_thr(n)) m_long[n][c] = 1;
          end
        end else if (!m_armed[n][c]) begin
          if (!bd[c]) m_armed[n][c] = 1;
        end else if (bd[c]) begin
          m_streak[n][c] = m_streak[n][c] + 1;
          if (m_streak[n][c] == 4) begin
            m_pr[n][c] = 1; m_streak[n][c] = 0; m_hold[n][c] = 0; m_frz[n][c] = 0;
          end
        end else begin
          m_streak[n][c] = 0;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (run_cmp) begin
      for (int n = 0; n < 2; n++) begin
        logic [CH-1:0] ep, el;
        logic [1:0]    ei;
        ep = '0; el = '0; ei = '0;
        for (int c = 0; c < CH; c++) begin
          ep[c] = m_pr[n][c];
          el[c] = m_long[n][c];
        end
        for (int c = CH - 1; c >= 0; c--) if (ep[c]) ei = 2'(c);
        if (n == 0) chk("cyc_def", {wp_a, wl_a, any_a, idx_a}, {ep, el, |ep, ei});
        else        chk("cyc_long", {wp_b, wl_b, any_b, idx_b}, {ep, el, |ep, ei});
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; bd = 4'b0001; ack = '0;
    step(2);
    run_cmp = 1;
    // Button held through reset is never reported.
    reset = 1'b0;
    step(3);
    chk("held_thru_reset_wp", wp_a, 4'b0000);
    bd = 4'b0000;
    step(1);

    // Default press on ch1: pending after the 4th edge.
    bd = 4'b0010;
    step(3);
    chk("press_ch1_early", wp_a, 4'b0000);
    step(1);
    chk("press_ch1", wp_a, 4'b0010);
    ack = 4'b0010;
    step(1);
    ack = '0;
    chk("ack_ch1", wp_a, 4'b0000);
    bd = 4'b0000;
    step(1);

    // Bounces on ch2 at dbCount 1, 2, 3.
    for (int k = 1; k <= 3; k++) begin
      bd = 4'b0100;
      step(k);
      bd = 4'b0000;
      step(1);
      chk("bounce_ch2", wp_a, 4'b0000);
    end

    // Long press on ch0 with threshold 5.
    bd = 4'b0001;
    step(4);
    chk("long_pressed", wp_b, 4'b0001);
    step(4);
    chk("long_not_yet", wl_b, 4'b0000);
    step(1);
    chk("long_set", wl_b, 4'b0001);
    chk("long_wp_kept", wp_b, 4'b0001);
    ack = 4'b0001;
    step(1);
    ack = '0;
    chk("long_ack", {wp_b, wl_b}, 8'h00);
    bd = 4'b0000;
    step(1);
    bd = 4'b0001;
    step(4);
    step(3);
    bd = 4'b0000;
    step(1);
    bd = 4'b0001;
    step(6);
    chk("frozen_no_long", {wp_b, wl_b}, 8'h10);
    ack = 4'b0001; bd = 4'b0000;
    step(1);
    ack = '0;
    step(1);

    // Two presses together, acked one at a time.
    bd = 4'b1010;
    step(4);
    chk("dual_idx", {any_a, idx_a}, {1'b1, 2'd1});
    ack = 4'b0010;
    step(1);
    chk("dual_idx_after_ack1", {any_a, idx_a}, {1'b1, 2'd3});
    ack = 4'b1000;
    step(1);
    chk("dual_none", {any_a, idx_a}, {1'b0, 2'd0});
    ack = '0; bd = '0;
    step(1);

    // Reset mid-operation: ch0 pressed, ch2 debouncing.
    bd = 4'b0001;
    step(4);
    bd = 4'b0101;
    step(2);
    reset = 1'b1;
    step(1);
    chk("reset_mid", {wp_a, wl_a, wp_b, wl_b, any_a, any_b}, 18'h0);
    reset = 1'b0; bd = '0;
    step(1);

    // Random traffic: slowly toggling levels, sporadic acks and resets.
    for (int t = 0; t < 3000; t++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 7) == 0) bd[c] = ~bd[c];
        ack[c] = ($urandom_range(0, 11) == 0);
      end
      reset = ($urandom_range(0, 499) == 0);
      step(1);
    end
    reset = 1'b0; ack = '0;
    step(1);
    run_cmp = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/button_press_bank.md
# button_press_bank

Parametrised multi-channel successor to the single-button press detector. Debounces `CHANNELS` independent raw button inputs with a configurable debounce length, latches one press event per button until acknowledged, and optionally flags long presses. Sits between the board's synchronised button inputs and the counter/control logic. It also provides an any-pressed summary and the lowest pending channel index for a simple polled consumer.

## Interface
- `CHANNELS`, 4: number of independent buttons, 1..32.
- `DEBOUNCE_CYCLES`, 3: consecutive down samples required after the first down sample, at least 1.
- `LONG_PRESS_CYCLES`, 0: down samples in the pressed state that make a press long; 0 disables long-press detection.
- `clock`  input  1  system clock; all logic is on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `buttonDown`  input  CHANNELS  raw level per button, already synchronised; 1 means down.
- `ackPress`  input  CHANNELS  per-channel acknowledge of a latched press.
- `wasPressed`  output  CHANNELS  per-channel debounced press pending.
- `wasLongPress`  output  CHANNELS  per-channel long press pending.
- `anyPressed`  output  1  OR of `wasPressed`.
- `pressedIndex`  output  max(1,$clog2(CHANNELS))  lowest index with `wasPressed`=1; 0 when none is pending.

## Operation
- Each channel runs an independent Moore FSM with states WAIT_UP, BTN_UP, DEBOUNCE and BTN_PRESSED. A debounce counter (`dbCount`) and a hold counter (`holdCount`) run alongside it.
- Reset puts every channel in WAIT_UP with both counters at 0 and all outputs at 0. A button held through reset is never reported.
- **WAIT_UP:** if `buttonDown`=0, go to BTN_UP; otherwise stay.
- **BTN_UP:** if `buttonDown`=1, go to DEBOUNCE with `dbCount`=1.
- **DEBOUNCE:**
  - If `buttonDown`=0, return to BTN_UP. This is a bounce and no event is produced.
  - Else if `dbCount`==DEBOUNCE_CYCLES, go to BTN_PRESSED with `holdCount`=0.
  - Else increment `dbCount`.
- **BTN_PRESSED:**
  - `wasPressed`=1.
  - `ackPress`=1 takes priority over everything else and moves to WAIT_UP, clearing `wasLongPress`.
  - A release in BTN_PRESSED does not leave the state. It freezes `holdCount` permanently for this press.
- **Long press** (LONG_PRESS_CYCLES>0):
  - While in BTN_PRESSED, not frozen, with `buttonDown`=1 and `wasLongPress`=0, `holdCount` increments.
  - `wasLongPress` is set on the edge where `holdCount` reaches LONG_PRESS_CYCLES.
  - It stays set until ack or reset. `wasPressed` stays 1 alongside it.
- **Counter widths:** $clog2 of the count maximum plus 1. `holdCount` saturates and never wraps.
- **Channel independence:** simultaneous events on different channels do not interact. An ack on a channel that is not in BTN_PRESSED is ignored.

## Timing
- All outputs are registered or decoded from state only; there are no input-to-output combinational paths.
- **Press latency:** button goes down before edge N (BTN_UP → DEBOUNCE). `wasPressed` is then high after edge N+DEBOUNCE_CYCLES, provided the input stays down for all sampled edges.
  - Default: 4 edges from BTN_UP.
- **Ack:** `ackPress` sampled high at edge M drops `wasPressed` and `wasLongPress` after edge M.
  - The next press is accepted only after the release has been sampled in WAIT_UP (WAIT_UP → BTN_UP → DEBOUNCE).
- **Ack and release on the same edge:** go to WAIT_UP, then BTN_UP on the next edge.
- **Long flag:** `wasLongPress` rises LONG_PRESS_CYCLES edges after `wasPressed` rises, if the input is held throughout.
- **Summary outputs:** `anyPressed` and `pressedIndex` are combinational from the registered `wasPressed` vector, in the same cycle.
- **Reset:** dominates ack and button inputs on any cycle, from any state mid-operation.

## Structure
- Shared package `buttonpress_pkg`: state enum (WAIT_UP, BTN_UP, DEBOUNCE, BTN_PRESSED) and a counter-width function.
- Sub-module `button_channel`: one FSM with both counters, parameterised by DEBOUNCE_CYCLES and LONG_PRESS_CYCLES.
- The top level instantiates CHANNELS copies of `button_channel` through a generate loop, plus the priority encoder for `pressedIndex`.

## Test plan
- Reset with channel 0 held down → channel 0 stays in WAIT_UP and all outputs stay 0. Release → BTN_UP one edge later.
- Defaults, press ch1 and hold → `wasPressed`=0010 after the 4th edge. Ack → 0000 next edge. Release → BTN_UP.
- Bounce on ch2 released during DEBOUNCE at `dbCount`=1, 2 and 3 → back to BTN_UP each time, with `wasPressed` never set.
- LONG_PRESS_CYCLES=5, ch0 held: `wasLongPress[0]` high 5 edges after `wasPressed[0]`. Repeat with release after 3 held edges → `wasLongPress` never set.
- ch3 and ch1 pressed together → `pressedIndex`=1 and `anyPressed`=1. Ack ch1 → `pressedIndex`=3. Ack ch3 → `anyPressed`=0, `pressedIndex`=0.
- Assert reset while ch0 is in BTN_PRESSED and ch2 is in DEBOUNCE → both in WAIT_UP and all outputs 0 on the next edge.
